mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while an
// access is outstanding, and drives the MEM/WB register to the writeback mux.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluResult,
    input  logic [DATA_W-1:0] ex_writeData,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              ex_memtoreg,
    input  logic              ex_regWrite,
    input  logic [REG_W-1:0]  ex_writeReg,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_memtoreg,
    output logic              wb_regWrite,
    output logic [DATA_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_address,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic              misalign
);

    state_t state_q, state_d;

    // Instruction held while the memory access is in flight
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_memtoreg;
    logic              lat_regWrite;
    logic [REG_W-1:0]  lat_writeReg;

    logic ex_memop;
    logic ex_aligned;
    logic alu_done;
    logic mis_done;
    logic lat_en;
    logic mem_done;

    assign ex_memop   = ex_memRead | ex_memWrite;
    assign ex_aligned = (ex_aluResult[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        alu_done = 1'b0;
        mis_done = 1'b0;
        lat_en   = 1'b0;
        mem_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_memop) begin
                        alu_done = 1'b1;
                    end else if (!ex_aligned) begin
                        mis_done = 1'b1;
                    end else begin
                        lat_en  = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ready && lat_we) begin
                    mem_done = 1'b1;
                    state_d  = IDLE;
                end else if (dmem_ready) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    mem_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = dmem_req & lat_we;
    assign dmem_addr  = lat_addr;
    assign dmem_wdata = lat_wdata;

    // A load with the write bit also set is performed as a load
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_we       <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_regWrite <= 1'b0;
            lat_writeReg <= '0;
        end else if (lat_en) begin
            lat_addr     <= ex_aluResult;
            lat_wdata    <= ex_writeData;
            lat_we       <= ex_memWrite & ~ex_memRead;
            lat_memtoreg <= ex_memtoreg;
            lat_regWrite <= ex_regWrite;
            lat_writeReg <= ex_writeReg;
        end
    end

    // MEM/WB register: valid and regWrite pulse, payload holds between completions
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_rd       <= '0;
            wb_address  <= '0;
            wb_writeReg <= '0;
            misalign    <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            misalign    <= 1'b0;
            if (alu_done || mis_done) begin
                wb_valid    <= 1'b1;
                wb_address  <= ex_aluResult;
                wb_memtoreg <= ex_memtoreg;
                wb_writeReg <= ex_writeReg;
                wb_regWrite <= ex_regWrite & ~mis_done;
                misalign    <= mis_done;
            end
            if (mem_done) begin
                wb_valid    <= 1'b1;
                wb_address  <= lat_addr;
                wb_memtoreg <= lat_memtoreg;
                wb_writeReg <= lat_writeReg;
                wb_regWrite <= lat_regWrite;
                if (state_q == WAIT) begin
                    wb_rd <= dmem_rdata;
                end
            end
        end
    end

endmodule
